mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ex_valid  input  1  instruction in MEM input latch is valid.
REQ-004 SHALL have port ex_opcode  input  4 (lc3b_opcode)  opcode of that instruction.
REQ-005 SHALL have port ex_address  input  16 (lc3b_word)  effective address from execute.
REQ-006 SHALL have port ex_store_data  input  16  SR value for stores.
REQ-007 SHALL have ports dmem_rdata  input  16, and dmem_resp  input  1  data-memory read data and completion.
REQ-008 SHALL have ports dmem_address  output  16; dmem_wdata  output  16; dmem_read  output  1; dmem_write  output  1; dmem_byte_enable  output  2.
REQ-009 SHALL have port mem_rdata  output  16  load result for the writeback register.
REQ-010 SHALL have port mem_stall  output  1  high = hold upstream latches and keep writeback register load low.

Function
REQ-011 Memory ops: LDR, LDB, LDI (reads); STR, STB, STI (writes); all others are non-memory ops.
REQ-012 FSM states: IDLE, ACCESS, INDIRECT, DONE.
REQ-013 IDLE: valid memory op -> ACCESS, mem_stall=1; otherwise stay IDLE, mem_stall=0, no dmem request.
REQ-014 ACCESS: address=ex_address; dmem_read=1 for LDR/LDB/LDI/STI, dmem_write=1 for STR/STB; mem_stall=1.
REQ-015 In ACCESS on dmem_resp: LDI/STI latch dmem_rdata into 16-bit pointer register -> INDIRECT; loads latch result into mem_rdata -> DONE; stores -> DONE.
REQ-016 INDIRECT: address=pointer; dmem_read=1 (LDI) or dmem_write=1 with wdata=ex_store_data (STI); mem_stall=1; on dmem_resp LDI latches result -> DONE.
REQ-017 DONE: no request, mem_stall=0 for exactly one cycle, then IDLE.
REQ-018 Request signals SHALL stay asserted and constant every cycle until dmem_resp; dmem_read and dmem_write never both high.
REQ-019 Word ops (LDR/STR/LDI/STI, pointer fetch): dmem_address bit 0 forced 0; byte_enable=2'b11.
REQ-020 LDB: full address driven; result = sign-extended dmem_rdata[15:8] if address[0]=1, else [7:0].
REQ-021 STB: dmem_wdata = {SR[7:0],SR[7:0]}; byte_enable = 2'b10 if address[0]=1, else 2'b01.
REQ-022 Latency with dmem_resp in the first request cycle: single-access op stalls 2 cycles (IDLE, ACCESS), indirect op 3 cycles.
REQ-023 Upstream inputs SHALL be held stable while mem_stall=1; the stage samples ex_opcode/ex_valid only in IDLE.
REQ-024 mem_rdata SHALL hold its last latched value through stores and non-memory ops.
REQ-025 dmem_resp outside ACCESS/INDIRECT SHALL be ignored.

Reset
REQ-026 reset high at a rising edge: state=IDLE, mem_rdata=0x0000, pointer=0x0000.
REQ-027 While reset is high, dmem_read, dmem_write and mem_stall SHALL be 0 regardless of state; mid-operation reset abandons the access.

Structure
REQ-028 lc3b_word, lc3b_opcode and opcode constants SHALL come from package lc3b_types; FSM state enum is local to the module.
REQ-029 mem_rdata and the pointer SHALL each be an instance of the existing parameterised register sub-module (width 16).

Verification
REQ-030 LDR, ex_address=0x3005, resp after 2 wait cycles, rdata=0xBEEF -> dmem_address=0x3004, byte_enable=11, stall 4 cycles, mem_rdata=0xBEEF in DONE.
REQ-031 LDB, ex_address=0x2001, rdata=0x80FF -> mem_rdata=0xFF80; ex_address=0x2000 -> 0xFFFF.
REQ-032 STB, SR=0x1234, ex_address=0x4003 -> dmem_wdata=0x3434, byte_enable=10, dmem_write held until resp.
REQ-033 LDI, ex_address=0x1000, first rdata=0x5000, second rdata=0x00AA -> second address 0x5000, mem_rdata=0x00AA, stall 3 cycles with immediate resp.
REQ-034 STI in INDIRECT, reset pulsed 1 cycle -> requests drop during reset, next state IDLE, mem_rdata=0x0000, mem_stall=0.
REQ-035 ADD valid, stray dmem_resp=1 -> no request, mem_stall=0, mem_rdata unchanged.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b word/opcode types and opcode classification helpers
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    localparam logic [1:0] BE_WORD = 2'b11;

    function automatic logic is_mem_op(lc3b_opcode op);
        return op inside {op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti};
    endfunction

    function automatic logic is_indirect_op(lc3b_opcode op);
        return op inside {op_ldi, op_sti};
    endfunction

    // Only direct stores write on the first access; STI reads its pointer first.
    function automatic logic first_access_writes(lc3b_opcode op);
        return op inside {op_str, op_stb};
    endfunction

    function automatic lc3b_word byte_load(lc3b_word rdata, logic high_byte);
        logic [7:0] b;
        b = high_byte ? rdata[15:8] : rdata[7:0];
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response bus between MEM stage and memory
interface mem_stage_if;
    import lc3b_types::*;

    lc3b_word   dmem_address;
    lc3b_word   dmem_wdata;
    logic       dmem_read;
    logic       dmem_write;
    logic [1:0] dmem_byte_enable;
    lc3b_word   dmem_rdata;
    logic       dmem_resp;

    modport master (
        output dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_stage_reg.sv
// rtl/mem_stage_reg.sv - parameterised load-enable register with synchronous clear
module mem_stage_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LC-3b MEM stage: sequences direct, byte and indirect data-memory accesses
module mem_stage
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  lc3b_opcode  ex_opcode,
    input  lc3b_word    ex_address,
    input  lc3b_word    ex_store_data,
    mem_stage_if.master dmem,
    output lc3b_word    mem_rdata,
    output logic        mem_stall
);
    typedef enum logic [1:0] {IDLE, ACCESS, INDIRECT, DONE} state_t;

    state_t     state;
    lc3b_opcode op_q;
    lc3b_word   addr_q;
    lc3b_word   wdata_q;
    logic [1:0] be_q;
    logic       read_q;
    logic       write_q;
    lc3b_word   pointer;

    logic     start;
    logic     is_byte_op;
    logic     ptr_load;
    logic     result_load;
    lc3b_word result_value;

    assign start      = ex_valid && is_mem_op(ex_opcode);
    assign is_byte_op = (ex_opcode == op_ldb) || (ex_opcode == op_stb);

    assign ptr_load    = (state == ACCESS) && dmem.dmem_resp && is_indirect_op(op_q);
    assign result_load = dmem.dmem_resp &&
                         (((state == ACCESS) && ((op_q == op_ldr) || (op_q == op_ldb))) ||
                          ((state == INDIRECT) && (op_q == op_ldi)));
    assign result_value = (op_q == op_ldb) ? byte_load(dmem.dmem_rdata, addr_q[0])
                                           : dmem.dmem_rdata;

    mem_stage_reg #(.WIDTH(16)) u_pointer (
        .clk   (clk),
        .reset (reset),
        .load  (ptr_load),
        .din   (dmem.dmem_rdata),
        .dout  (pointer)
    );

    mem_stage_reg #(.WIDTH(16)) u_mem_rdata (
        .clk   (clk),
        .reset (reset),
        .load  (result_load),
        .din   (result_value),
        .dout  (mem_rdata)
    );

    // Request qualifiers are registered on state entry so they stay constant until dmem_resp.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= op_br;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCESS;
                        op_q    <= ex_opcode;
                        addr_q  <= ex_address & (is_byte_op ? 16'hFFFF : 16'hFFFE);
                        wdata_q <= (ex_opcode == op_stb) ? {2{ex_store_data[7:0]}}
                                                         : ex_store_data;
                        if (ex_opcode == op_stb) begin
                            be_q <= ex_address[0] ? 2'b10 : 2'b01;
                        end else begin
                            be_q <= BE_WORD;
                        end
                        read_q  <= !first_access_writes(ex_opcode);
                        write_q <= first_access_writes(ex_opcode);
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_resp) begin
                        if (is_indirect_op(op_q)) begin
                            state   <= INDIRECT;
                            be_q    <= BE_WORD;
                            read_q  <= (op_q == op_ldi);
                            write_q <= (op_q == op_sti);
                        end else begin
                            state   <= DONE;
                            read_q  <= 1'b0;
                            write_q <= 1'b0;
                        end
                    end
                end
                INDIRECT: begin
                    if (dmem.dmem_resp) begin
                        state   <= DONE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_address     = (state == INDIRECT) ? (pointer & 16'hFFFE) : addr_q;
    assign dmem.dmem_wdata       = wdata_q;
    assign dmem.dmem_byte_enable = be_q;
    assign dmem.dmem_read        = read_q && !reset;
    assign dmem.dmem_write       = write_q && !reset;

    // IDLE stalls combinationally so upstream holds the instruction while the access starts.
    assign mem_stall = !reset && ((state == ACCESS) || (state == INDIRECT) ||
                                  ((state == IDLE) && start));

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against an access-list reference model
module tb_mem_stage;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    lc3b_opcode ex_opcode;
    lc3b_word   ex_address;
    lc3b_word   ex_store_data;
    lc3b_word   mem_rdata;
    logic       mem_stall;

    mem_stage_if dmem();

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_address    (ex_address),
        .ex_store_data (ex_store_data),
        .dmem          (dmem),
        .mem_rdata     (mem_rdata),
        .mem_stall     (mem_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        lc3b_word   addr;
        logic       wr;
        logic       chk_be;
        logic [1:0] be;
        lc3b_word   wdata;
    } acc_t;

    int       checks = 0;
    int       errors = 0;
    lc3b_word model_rdata;

    function automatic acc_t mk(lc3b_word a, logic wr, logic chk_be, logic [1:0] be, lc3b_word wd);
        acc_t r;
        r.addr = a; r.wr = wr; r.chk_be = chk_be; r.be = be; r.wdata = wd;
        return r;
    endfunction

    task automatic run_op(input logic v, input logic [3:0] opc, input lc3b_word addr,
                          input lc3b_word sr, input lc3b_word r0, input lc3b_word r1,
                          input int w0, input int w1, input string name);
        acc_t       acc[$];
        lc3b_word   rd[2];
        int         wt[2];
        int         exp_stall, k, w, stalls;
        bit         done;
        lc3b_word   exp_res;
        lc3b_opcode op;
        logic [7:0] b;
        op = lc3b_opcode'(opc);
        rd[0] = r0; rd[1] = r1; wt[0] = w0; wt[1] = w1;
        exp_res = model_rdata;
        k = 0; w = 0; stalls = 0; done = 0;
        if (v) begin
            case (op)
                op_ldr: begin acc.push_back(mk(addr & 16'hFFFE, 0, 1, 2'b11, 0)); exp_res = r0; end
                op_ldb: begin
                    acc.push_back(mk(addr, 0, 0, 2'b00, 0));
                    b = addr[0] ? r0[15:8] : r0[7:0];
                    exp_res = (b >= 8'h80) ? (16'hFF00 + 16'(b)) : 16'(b);
                end
                op_ldi: begin
                    acc.push_back(mk(addr & 16'hFFFE, 0, 1, 2'b11, 0));
                    acc.push_back(mk(r0 & 16'hFFFE, 0, 1, 2'b11, 0));
                    exp_res = r1;
                end
                op_str: acc.push_back(mk(addr & 16'hFFFE, 1, 1, 2'b11, sr));
                op_stb: acc.push_back(mk(addr, 1, 1, addr[0] ? 2'b10 : 2'b01,
                                         16'(sr[7:0]) * 16'h0101));
                op_sti: begin
                    acc.push_back(mk(addr & 16'hFFFE, 0, 1, 2'b11, 0));
                    acc.push_back(mk(r0 & 16'hFFFE, 1, 1, 2'b11, sr));
                end
                default: ;
            endcase
        end
        exp_stall = 0;
        if (acc.size() > 0) exp_stall = 1 + (wt[0] + 1);
        if (acc.size() > 1) exp_stall += wt[1] + 1;

        @(negedge clk);
        ex_valid = v; ex_opcode = op; ex_address = addr; ex_store_data = sr;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem.dmem_resp = 1'b0;
            #1;
            if (mem_stall) stalls++;
            checks++;
            if (dmem.dmem_read && dmem.dmem_write) begin
                errors++; $display("FAIL %s read_and_write both high", name);
            end
            if (dmem.dmem_read || dmem.dmem_write) begin
                checks++;
                if (k >= acc.size()) begin
                    errors++; $display("FAIL %s unexpected request addr %h", name, dmem.dmem_address);
                end else begin
                    if (dmem.dmem_address !== acc[k].addr || dmem.dmem_write !== acc[k].wr) begin
                        errors++;
                        $display("FAIL %s access%0d addr %h wr %b want addr %h wr %b", name, k,
                                 dmem.dmem_address, dmem.dmem_write, acc[k].addr, acc[k].wr);
                    end
                    if (acc[k].chk_be) begin
                        checks++;
                        if (dmem.dmem_byte_enable !== acc[k].be) begin
                            errors++;
                            $display("FAIL %s byte_enable got %b want %b", name,
                                     dmem.dmem_byte_enable, acc[k].be);
                        end
                    end
                    if (acc[k].wr) begin
                        checks++;
                        if (dmem.dmem_wdata !== acc[k].wdata) begin
                            errors++;
                            $display("FAIL %s wdata got %h want %h", name, dmem.dmem_wdata, acc[k].wdata);
                        end
                    end
                    if (w == wt[k]) begin
                        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = rd[k]; k++; w = 0;
                    end else begin
                        dmem.dmem_rdata = 16'($urandom); w++;
                    end
                end
            end else if (!mem_stall) begin
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout waiting for stall release", name);
        end
        checks++;
        if (mem_rdata !== exp_res) begin
            errors++; $display("FAIL %s mem_rdata got %h want %h", name, mem_rdata, exp_res);
        end
        checks++;
        if (stalls != exp_stall || k != acc.size()) begin
            errors++;
            $display("FAIL %s stall cycles %0d accesses %0d want %0d and %0d", name, stalls, k,
                     exp_stall, acc.size());
        end
        // A stray response after completion (or for a non-memory op) must be ignored.
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'($urandom);
        if (acc.size() > 0) ex_valid = 1'b0;
        @(negedge clk);
        dmem.dmem_resp = 1'b0;
        #1;
        checks++;
        if (mem_stall !== (v && is_mem_op(op) && acc.size() == 0) || dmem.dmem_read || dmem.dmem_write
            || mem_rdata !== exp_res) begin
            errors++;
            $display("FAIL %s idle_after stall %b rd %b wr %b mem_rdata %h want %h", name, mem_stall,
                     dmem.dmem_read, dmem.dmem_write, mem_rdata, exp_res);
        end
        ex_valid = 1'b0;
        model_rdata = exp_res;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b1; ex_opcode = op_ldr; ex_address = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (mem_stall !== 1'b0 || dmem.dmem_read !== 1'b0 || dmem.dmem_write !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs stall %b rd %b wr %b want 0 0 0", mem_stall,
                         dmem.dmem_read, dmem.dmem_write);
            end
        end
        checks++;
        if (mem_rdata !== 16'h0000) begin
            errors++; $display("FAIL reset_mem_rdata got %h want 0000", mem_rdata);
        end
        reset = 1'b0; ex_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (mem_stall !== 1'b0 || dmem.dmem_read !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++; $display("FAIL reset_release stall %b mem_rdata %h want 0 0000", mem_stall, mem_rdata);
        end
        model_rdata = 16'h0000;
    endtask

    task automatic test_reset_mid_sti();
        @(negedge clk);
        ex_valid = 1'b1; ex_opcode = op_sti; ex_address = 16'h1234; ex_store_data = 16'hCAFE;
        @(negedge clk);
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'h5000;
        @(negedge clk);
        dmem.dmem_resp = 1'b0; #1;
        checks++;
        if (dmem.dmem_write !== 1'b1 || dmem.dmem_address !== 16'h5000) begin
            errors++;
            $display("FAIL sti_indirect wr %b addr %h want 1 5000", dmem.dmem_write, dmem.dmem_address);
        end
        reset = 1'b1; #1;
        checks++;
        if (dmem.dmem_write !== 1'b0 || dmem.dmem_read !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset rd %b wr %b stall %b want 0 0 0", dmem.dmem_read,
                     dmem.dmem_write, mem_stall);
        end
        @(negedge clk);
        reset = 1'b0; ex_valid = 1'b0; #1;
        checks++;
        if (mem_stall !== 1'b0 || dmem.dmem_write !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL after_mid_reset stall %b wr %b mem_rdata %h want 0 0 0000", mem_stall,
                     dmem.dmem_write, mem_rdata);
        end
        model_rdata = 16'h0000;
    endtask

    task automatic test_directed();
        run_op(1, op_ldr, 16'h3005, 16'h0000, 16'hBEEF, 16'h0, 2, 0, "ldr_wait2");
        run_op(1, op_ldb, 16'h2001, 16'h0000, 16'h80FF, 16'h0, 1, 0, "ldb_high");
        run_op(1, op_ldb, 16'h2000, 16'h0000, 16'h80FF, 16'h0, 0, 0, "ldb_low");
        run_op(1, op_stb, 16'h4003, 16'h1234, 16'h0000, 16'h0, 3, 0, "stb_high");
        run_op(1, op_ldi, 16'h1000, 16'h0000, 16'h5000, 16'h00AA, 0, 0, "ldi_immediate");
        run_op(1, op_add, 16'h2222, 16'h3333, 16'h4444, 16'h0, 0, 0, "add_stray_resp");
        run_op(1, op_str, 16'h6001, 16'hA5A5, 16'h0000, 16'h0, 1, 0, "str_hold_rdata");
        run_op(1, op_sti, 16'h7777, 16'h0F0F, 16'h9001, 16'h0, 2, 1, "sti_wait");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_opcode = op_br; ex_address = '0; ex_store_data = '0;
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = '0;
        model_rdata = '0;
        test_reset();
        test_directed();
        test_reset_mid_sti();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
